mem_arbiter: RTL and testbench

Single-port memory arbiter between the CPU's separate instruction and data memory ports and one shared request/acknowledge memory bus. Per CPU pipeline step it serialises the data access first, then the instruction fetch, and holds both CPU ready signals low until both complete. It then releases the step with registered read data. It produces the `instr_mem_ready_i`/`data_mem_ready_i` inputs the CPU uses as its global stall.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/bus_timeout_counter.sv | 39 +++
 rtl/mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// Holds the FSM state encoding, the all-lanes byte enable and the timeout counter width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_REQ  = 2'd1,
        INSTR_REQ = 2'd2,
        RESP      = 2'd3
    } arb_state_e;

    localparam logic [3:0] BE_ALL   = 4'hF;
    localparam int         TO_CNT_W = 8;

endpackage

// File: rtl/bus_timeout_counter.sv
// Bus wait counter: cleared on entry to a request state, counts non-acked cycles.
// Ports: clk_i, rst_i, clear_i, en_i in; done_o high once the count equals TIMEOUT_CYCLES.
module bus_timeout_counter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises a CPU step's data access then instruction fetch onto one req/ack bus.
// Ports: CPU instr/data request sides (_i) with ready/data (_o), bus req/we/addr/wdata/be out, ack/rdata in, bus_err_o.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_rd_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_ready_o,
    output logic [31:0] instr_data_o,
    input  logic        data_rd_i,
    input  logic        data_wr_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  byte_select_i,
    output logic        data_ready_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        bus_err_o
);

    arb_state_e  state_q, state_d;
    logic        ipend_q, ipend_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] iaddr_q, iaddr_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        err_q, err_d;

    logic any_req;
    logic data_req;
    logic in_bus;
    logic to_done;
    logic step;

    assign data_req = data_rd_i | data_wr_i;
    assign any_req  = data_req | instr_rd_i;
    assign in_bus   = (state_q == DATA_REQ) || (state_q == INSTR_REQ);
    // An access finishes on ack, or is abandoned once the wait budget is spent.
    assign step     = mem_ack_i | to_done;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_to (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(state_d != state_q),
        .en_i   (in_bus && !mem_ack_i),
        .done_o (to_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (data_req) begin
                    state_d = DATA_REQ;
                end else if (instr_rd_i) begin
                    state_d = INSTR_REQ;
                end
            end
            DATA_REQ: begin
                if (step) begin
                    state_d = ipend_q ? INSTR_REQ : RESP;
                end
            end
            INSTR_REQ: begin
                if (step) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_be_o      = '0;
        instr_ready_o = 1'b0;
        data_ready_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                instr_ready_o = !any_req;
                data_ready_o  = !any_req;
            end
            DATA_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = daddr_q;
                if (wr_q) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = wdata_q;
                    mem_be_o    = be_q;
                end else begin
                    mem_be_o = BE_ALL;
                end
            end
            INSTR_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = iaddr_q;
                mem_be_o   = BE_ALL;
            end
            RESP: begin
                instr_ready_o = 1'b1;
                data_ready_o  = 1'b1;
            end
        endcase
    end

    always_comb begin
        ipend_d  = ipend_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        iaddr_d  = iaddr_q;
        daddr_d  = daddr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        idata_d  = idata_q;
        drdata_d = drdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    ipend_d = instr_rd_i;
                    rd_d    = data_rd_i;
                    wr_d    = data_wr_i;
                    iaddr_d = instr_addr_i;
                    daddr_d = data_addr_i;
                    wdata_d = data_wdata_i;
                    be_d    = byte_select_i;
                end
            end
            DATA_REQ: begin
                if (step) begin
                    // A read+write collision is a store; its read result is 0.
                    if (rd_q && wr_q) begin
                        drdata_d = '0;
                    end else if (rd_q) begin
                        drdata_d = mem_ack_i ? mem_rdata_i : '0;
                    end
                    if (!mem_ack_i) begin
                        err_d = 1'b1;
                    end
                end
            end
            INSTR_REQ: begin
                if (step) begin
                    idata_d = mem_ack_i ? mem_rdata_i : '0;
                    if (!mem_ack_i) begin
                        err_d = 1'b1;
                    end
                end
            end
            RESP: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ipend_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            iaddr_q  <= '0;
            daddr_q  <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            idata_q  <= '0;
            drdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            ipend_q  <= ipend_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            iaddr_q  <= iaddr_d;
            daddr_q  <= daddr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            idata_q  <= idata_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
        end
    end

    assign instr_data_o = idata_q;
    assign data_rdata_o = drdata_q;
    assign bus_err_o    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-transaction cycle timeline model
// built from the access rules, checked every cycle, plus directed literal cases.
module tb_mem_arbiter;

    localparam int N = 4;
    localparam int TMAX = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        instr_rd_i;
    logic [31:0] instr_addr_i;
    logic        instr_ready_o;
    logic [31:0] instr_data_o;
    logic        data_rd_i;
    logic        data_wr_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  byte_select_i;
    logic        data_ready_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        bus_err_o;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .instr_rd_i   (instr_rd_i),
        .instr_addr_i (instr_addr_i),
        .instr_ready_o(instr_ready_o),
        .instr_data_o (instr_data_o),
        .data_rd_i    (data_rd_i),
        .data_wr_i    (data_wr_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .byte_select_i(byte_select_i),
        .data_ready_o (data_ready_o),
        .data_rdata_o (data_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .bus_err_o    (bus_err_o)
    );

    int checks = 0;
    int errors = 0;

    // Expected per-cycle timeline of the current transaction.
    logic        t_req  [TMAX];
    logic        t_we   [TMAX];
    logic [31:0] t_addr [TMAX];
    logic [31:0] t_wdata[TMAX];
    logic [3:0]  t_be   [TMAX];
    logic        t_rdy  [TMAX];
    logic        t_ack  [TMAX];
    logic [31:0] t_rdata[TMAX];
    int          tlen;
    int          cur;
    bit          active = 1'b0;

    logic [31:0] m_idata  = '0;
    logic [31:0] m_drdata = '0;
    logic        m_err    = 1'b0;

    int          obs_rdy;
    int          obs_reqs;
    int          obs_we;
    bit          obs_have;
    logic [31:0] obs_first;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus access: ack after 'waits' wait cycles, or abandoned after N+1 cycles.
    task automatic add_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input int waits, input logic [31:0] rd,
                              output logic [31:0] got);
        int n;
        n = (waits > N) ? N + 1 : waits + 1;
        for (int j = 0; j < n; j++) begin
            t_req[tlen]   = 1'b1;
            t_we[tlen]    = we;
            t_addr[tlen]  = a;
            t_wdata[tlen] = wd;
            t_be[tlen]    = be;
            t_rdy[tlen]   = 1'b0;
            t_ack[tlen]   = (j == waits);
            t_rdata[tlen] = (j == waits) ? rd : $urandom;
            tlen++;
        end
        if (waits > N) begin
            got   = '0;
            m_err = 1'b1;
        end else begin
            got = rd;
        end
    endtask

    task automatic run_txn(input logic irq, input logic drd, input logic dwr,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [3:0] bs,
                           input int wdw, input int wiw,
                           input logic [31:0] rdd, input logic [31:0] rdi);
        logic [31:0] got;
        t_req[0]   = 1'b0;
        t_we[0]    = 1'b0;
        t_addr[0]  = '0;
        t_wdata[0] = '0;
        t_be[0]    = '0;
        t_rdy[0]   = !(irq | drd | dwr);
        t_ack[0]   = 1'($urandom);
        t_rdata[0] = $urandom;
        tlen = 1;
        if (drd | dwr) begin
            add_access(dwr, da, wd, dwr ? bs : 4'hF, wdw, rdd, got);
            if (drd && dwr) m_drdata = '0;
            else if (drd) m_drdata = got;
        end
        if (irq) begin
            add_access(1'b0, ia, 32'h0, 4'hF, wiw, rdi, got);
            m_idata = got;
        end
        t_req[tlen]   = 1'b0;
        t_we[tlen]    = 1'b0;
        t_addr[tlen]  = '0;
        t_wdata[tlen] = '0;
        t_be[tlen]    = '0;
        t_rdy[tlen]   = 1'b1;
        t_ack[tlen]   = 1'($urandom);
        t_rdata[tlen] = $urandom;
        tlen++;

        obs_rdy  = -1;
        obs_reqs = 0;
        obs_we   = 0;
        obs_have = 1'b0;
        for (int c = 0; c < tlen; c++) begin
            cur = c;
            if (c == 0) begin
                instr_rd_i    = irq;
                instr_addr_i  = ia;
                data_rd_i     = drd;
                data_wr_i     = dwr;
                data_addr_i   = da;
                data_wdata_i  = wd;
                byte_select_i = bs;
            end else begin
                instr_rd_i    = 1'($urandom);
                instr_addr_i  = $urandom;
                data_rd_i     = 1'($urandom);
                data_wr_i     = 1'($urandom);
                data_addr_i   = $urandom;
                data_wdata_i  = $urandom;
                byte_select_i = 4'($urandom);
            end
            mem_ack_i   = t_ack[c];
            mem_rdata_i = t_rdata[c];
            active = 1'b1;
            @(posedge clk);
            #1;
        end
        active     = 1'b0;
        instr_rd_i = 1'b0;
        data_rd_i  = 1'b0;
        data_wr_i  = 1'b0;
        mem_ack_i  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (active) begin
            chk1("req", mem_req_o, t_req[cur]);
            if (t_req[cur]) begin
                chk1("we", mem_we_o, t_we[cur]);
                chk32("addr", mem_addr_o, t_addr[cur]);
                chk32("be", {28'h0, mem_be_o}, {28'h0, t_be[cur]});
                if (t_we[cur]) chk32("wdata", mem_wdata_o, t_wdata[cur]);
                obs_reqs++;
                if (mem_we_o) obs_we++;
                if (!obs_have) begin
                    obs_have  = 1'b1;
                    obs_first = mem_addr_o;
                end
            end else begin
                chk32("idle_bus", mem_addr_o | mem_wdata_o | {27'h0, mem_be_o, mem_we_o}, 32'h0);
            end
            chk1("instr_ready", instr_ready_o, t_rdy[cur]);
            chk1("data_ready", data_ready_o, t_rdy[cur]);
            if (instr_ready_o && data_ready_o && obs_rdy < 0) obs_rdy = cur;
            if (cur == tlen - 1) begin
                chk32("instr_data", instr_data_o, m_idata);
                chk32("data_rdata", data_rdata_o, m_drdata);
                chk1("bus_err", bus_err_o, m_err);
            end
        end
    end

    initial begin
        logic irq, drd, dwr;
        int   wdw, wiw;
        rst_i = 1'b1;
        instr_rd_i = 1'b0;
        instr_addr_i = '0;
        data_rd_i = 1'b0;
        data_wr_i = 1'b0;
        data_addr_i = '0;
        data_wdata_i = '0;
        byte_select_i = '0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_irdy", instr_ready_o, 1'b1);
        chk1("rst_drdy", data_ready_o, 1'b1);
        chk32("rst_bus", mem_addr_o | mem_wdata_o | {27'h0, mem_be_o, mem_we_o}, 32'h0);
        chk32("rst_idata", instr_data_o, 32'h0);
        chk32("rst_drdata", data_rdata_o, 32'h0);
        chk1("rst_err", bus_err_o, 1'b0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Fetch only, zero-wait.
        run_txn(1, 0, 0, 32'h10, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 32'h00500093);
        chk32("t1_rdy_cycle", obs_rdy + 1, 3);
        chk32("t1_reqs", obs_reqs, 1);
        chk32("t1_idata", instr_data_o, 32'h00500093);

        // Load with 2 wait cycles plus fetch.
        run_txn(1, 1, 0, 32'h14, 32'h2000, 32'h0, 4'h0, 2, 0, 32'hDEADBEEF, 32'h00000013);
        chk32("t2_rdy_cycle", obs_rdy + 1, 6);
        chk32("t2_reqs", obs_reqs, 4);
        chk32("t2_first_addr", obs_first, 32'h2000);
        chk32("t2_drdata", data_rdata_o, 32'hDEADBEEF);

        // Read+write collision: store issued, read data forced to 0.
        run_txn(0, 1, 1, 32'h0, 32'h3000, 32'h12345678, 4'hF, 0, 0, 32'hCAFEF00D, 32'h0);
        chk32("t5_we_cycles", obs_we, 1);
        chk32("t5_drdata", data_rdata_o, 32'h0);

        // Store with byte enable, then fetch.
        run_txn(1, 0, 1, 32'h18, 32'h2004, 32'h0000AB00, 4'b0010, 0, 1, 32'h0, 32'h11111111);
        chk32("t3_we_cycles", obs_we, 1);
        chk32("t3_rdy_cycle", obs_rdy + 1, 5);
        chk32("t3_first_addr", obs_first, 32'h2004);

        for (int k = 0; k < 40; k++) begin
            irq = 1'($urandom);
            drd = 1'($urandom);
            dwr = ($urandom_range(0, 3) == 0);
            if (!(irq | drd | dwr)) irq = 1'b1;
            wdw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            wiw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            run_txn(irq, drd, dwr, $urandom, $urandom, $urandom, 4'($urandom),
                    wdw, wiw, $urandom, $urandom);
        end

        // Fetch never acked: timeout after N+1 request cycles.
        run_txn(1, 0, 0, 32'h20, 32'h0, 32'h0, 4'h0, 0, 99, 32'h0, 32'h0);
        chk32("t4_reqs", obs_reqs, N + 1);
        chk32("t4_rdy_cycle", obs_rdy + 1, N + 3);
        chk1("t4_err", bus_err_o, 1'b1);
        chk32("t4_idata", instr_data_o, 32'h0);

        for (int k = 0; k < 5; k++) begin
            run_txn(1, 1, 0, $urandom, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom, $urandom);
        end
        chk1("err_sticky", bus_err_o, 1'b1);

        // Reset while a fetch waits for ack.
        instr_rd_i   = 1'b1;
        instr_addr_i = 32'h40;
        mem_ack_i    = 1'b0;
        @(posedge clk);
        #1;
        instr_rd_i = 1'b0;
        @(posedge clk);
        #1;
        chk1("pre_rst_req", mem_req_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        m_err = 1'b0;
        chk1("mid_rst_req", mem_req_o, 1'b0);
        chk1("mid_rst_err", bus_err_o, 1'b0);
        chk32("mid_rst_idata", instr_data_o, 32'h0);
        chk32("mid_rst_drdata", data_rdata_o, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk1("post_rst_req", mem_req_o, 1'b0);
            chk1("post_rst_rdy", instr_ready_o & data_ready_o, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
